formal_output_checker: RTL and testbench

//  Synthesizable scoreboard downstream of the formal-verification fabric/benchmark pair.

---
 rtl/formal_output_checker.sv | 111 +++++++++++
 tb/tb_formal_output_checker.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/formal_output_checker.sv
// Scoreboard comparing fabric outputs against benchmark outputs: skips warm-up, checks a fixed
// window, counts mismatch episodes. Optional per-bit sticky vector via CHECKER_STICKY_VEC_EN.
module formal_output_checker #(
  parameter int WIDTH       = 1,
  parameter int SKIP_CYCLES = 1,
  parameter int RUN_CYCLES  = 2,
  parameter int ERR_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] gfpga_out,
  input  logic [WIDTH-1:0] bench_out,
  input  logic [WIDTH-1:0] bench_known,
  output logic             busy,
  output logic             mismatch_flag,
  output logic [ERR_W-1:0] nb_error,
  output logic [ERR_W-1:0] first_err_cycle,
  output logic             done,
  output logic             pass
`ifdef CHECKER_STICKY_VEC_EN
  ,
  output logic [WIDTH-1:0] err_vec
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SKIP  = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [1:0] ST_FIRST = (SKIP_CYCLES > 0) ? ST_SKIP : ST_CHECK;

  // The terminal counters are sized from the cycle counts, not ERR_W, so long runs still end.
  localparam int SW = (SKIP_CYCLES > 0) ? $clog2(SKIP_CYCLES + 1) : 1;
  localparam int RW = $clog2(RUN_CYCLES + 1);
  localparam logic [SW-1:0]    SKIP_LAST = SW'((SKIP_CYCLES > 0) ? SKIP_CYCLES - 1 : 0);
  localparam logic [RW-1:0]    RUN_LAST  = RW'(RUN_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;

  logic [1:0]       state;
  logic [SW-1:0]    skip_cnt;
  logic [RW-1:0]    run_cnt;
  logic [ERR_W-1:0] check_idx;
  logic [WIDTH-1:0] diff;
  logic             mis_now;
  logic             new_episode;

  assign diff        = (gfpga_out ^ bench_out) & bench_known;
  assign mis_now     = |diff;
  assign new_episode = mis_now & ~mismatch_flag;

  assign busy = (state == ST_SKIP) || (state == ST_CHECK);
  assign done = (state == ST_DONE);
  assign pass = done && (nb_error == '0);

  // NOTE: state is updated with non-blocking assignments so every branch sees pre-edge values;
  // the reset is synchronous, so it sits inside the clocked block as an ordinary priority branch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      skip_cnt        <= '0;
      run_cnt         <= '0;
      check_idx       <= '0;
      nb_error        <= '0;
      first_err_cycle <= '0;
      mismatch_flag   <= 1'b0;
`ifdef CHECKER_STICKY_VEC_EN
      err_vec         <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state           <= ST_FIRST;
            skip_cnt        <= '0;
            run_cnt         <= '0;
            check_idx       <= '0;
            nb_error        <= '0;
            first_err_cycle <= '0;
            mismatch_flag   <= 1'b0;
`ifdef CHECKER_STICKY_VEC_EN
            err_vec         <= '0;
`endif
          end
        end

        ST_SKIP: begin
          if (skip_cnt == SKIP_LAST) state <= ST_CHECK;
          else skip_cnt <= skip_cnt + SW'(1);
        end

        ST_CHECK: begin
          mismatch_flag <= mis_now;
          // Consecutive mismatching cycles form one episode; the count sticks at all-ones.
          if (new_episode && (nb_error != ERR_MAX)) nb_error <= nb_error + ERR_W'(1);
          if (new_episode && (nb_error == '0)) first_err_cycle <= check_idx;
          if (check_idx != ERR_MAX) check_idx <= check_idx + ERR_W'(1);
`ifdef CHECKER_STICKY_VEC_EN
          err_vec <= err_vec | diff;
`endif
          if (run_cnt == RUN_LAST) state <= ST_DONE;
          else run_cnt <= run_cnt + RW'(1);
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_formal_output_checker.sv
// Self-checking bench for formal_output_checker: randomized runs scored by a sequence-level
// reference model, plus directed reset, skip, don't-care and saturation scenarios.
module tb_formal_output_checker;

  localparam int W   = 4;
  localparam int SK  = 2;
  localparam int RN  = 6;
  localparam int EW  = 16;
  localparam int W2  = 2;
  localparam int RN2 = 10;
  localparam int EW2 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, start2;
  logic [W-1:0]  g, b, k;
  logic [W2-1:0] g2, b2, k2;

  logic          busy, flag, done, pass;
  logic [EW-1:0] nb, first;
  logic          busy2, flag2, done2, pass2;
  logic [EW2-1:0] nb2, first2;
`ifdef CHECKER_STICKY_VEC_EN
  logic [W-1:0]  err_vec;
  logic [W2-1:0] err_vec2;
`endif

  formal_output_checker #(.WIDTH(W), .SKIP_CYCLES(SK), .RUN_CYCLES(RN), .ERR_W(EW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .gfpga_out(g), .bench_out(b), .bench_known(k),
    .busy(busy), .mismatch_flag(flag), .nb_error(nb), .first_err_cycle(first),
    .done(done), .pass(pass)
`ifdef CHECKER_STICKY_VEC_EN
    , .err_vec(err_vec)
`endif
  );

  formal_output_checker #(.WIDTH(W2), .SKIP_CYCLES(0), .RUN_CYCLES(RN2), .ERR_W(EW2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .gfpga_out(g2), .bench_out(b2), .bench_known(k2),
    .busy(busy2), .mismatch_flag(flag2), .nb_error(nb2), .first_err_cycle(first2),
    .done(done2), .pass(pass2)
`ifdef CHECKER_STICKY_VEC_EN
    , .err_vec(err_vec2)
`endif
  );

  int total = 0;
  int bad   = 0;

  bit           mis_q[$];
  bit           cur_mis;
  logic [W-1:0] vec_model;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: a check cycle mismatches if any bit is known and differs.
  function automatic bit ref_mis(input logic [W-1:0] gg, input logic [W-1:0] bb,
                                 input logic [W-1:0] kk);
    for (int i = 0; i < W; i++)
      if (kk[i] && (gg[i] != bb[i])) return 1'b1;
    return 1'b0;
  endfunction

  // Episodes = runs of consecutive mismatching check cycles, clamped at maxv.
  function automatic int exp_episodes(input int maxv);
    int n = 0;
    for (int i = 0; i < mis_q.size(); i++)
      if (mis_q[i] && (i == 0 || !mis_q[i-1])) n++;
    return (n > maxv) ? maxv : n;
  endfunction

  function automatic int exp_first();
    for (int i = 0; i < mis_q.size(); i++)
      if (mis_q[i]) return i;
    return 0;
  endfunction

  // mode 0: equal values, optionally one known bit flipped; 1: fully random; 2: nothing known.
  task automatic set_inputs(input int mode, input bit want);
    int j;
    g = W'($urandom);
    b = g;
    k = W'($urandom);
    case (mode)
      0: if (want) begin
           j = int'($urandom_range(W - 1, 0));
           k[j] = 1'b1;
           b[j] = ~b[j];
         end
      1: b = W'($urandom);
      default: begin
        b = W'($urandom);
        k = '0;
      end
    endcase
    cur_mis = ref_mis(g, b, k);
  endtask

  task automatic run_main(input string tag, input int mode, input bit [RN-1:0] pat,
                          input bit skip_bad);
    int exp_nb;
    mis_q.delete();
    vec_model = '0;
    @(negedge clk);
    start = 1'b1;
    set_inputs(1, 1'b0);
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_skip"}, busy, 1);
    for (int s = 0; s < SK; s++) begin
      set_inputs(0, skip_bad);
      @(negedge clk);
    end
    for (int i = 0; i < RN; i++) begin
      set_inputs(mode, pat[i]);
      mis_q.push_back(cur_mis);
      for (int j = 0; j < W; j++)
        if (k[j] && (g[j] != b[j])) vec_model[j] = 1'b1;
      @(negedge clk);
    end
    exp_nb = exp_episodes(2 ** EW - 1);
    check({tag, "_done"}, done, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_nb_error"}, nb, exp_nb);
    check({tag, "_first_err"}, first, exp_first());
    check({tag, "_flag"}, flag, mis_q[RN-1]);
    check({tag, "_pass"}, pass, exp_nb == 0);
`ifdef CHECKER_STICKY_VEC_EN
    check({tag, "_err_vec"}, err_vec, vec_model);
`endif
    set_inputs(1, 1'b0);
    @(negedge clk);
    check({tag, "_done_hold"}, done, 1);
    check({tag, "_flag_hold"}, flag, mis_q[RN-1]);
    check({tag, "_nb_hold"}, nb, exp_nb);
  endtask

  initial begin
    bit [RN-1:0] p;
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
    g = '0; b = '0; k = '0; g2 = '0; b2 = '0; k2 = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_nb", nb, 0);
    check("rst_first", first, 0);
    check("rst_flag", flag, 0);
    check("rst_done2", done2, 0);
    check("rst_nb2", nb2, 0);
    rst_n = 1'b1;

    run_main("clean", 0, '0, 1'b0);
    run_main("directed", 0, 6'b010110, 1'b0);
    run_main("skip_only", 0, '0, 1'b1);
    run_main("unknown", 2, '1, 1'b1);
    repeat (6) run_main("rand", 1, '0, 1'b0);
    repeat (4) begin
      p = RN'($urandom);
      run_main("pattern", 0, p, 1'b0);
    end

    // Reset mid-CHECK after one episode: everything returns to zero, then a clean run.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int s = 0; s < SK; s++) begin
      set_inputs(0, 1'b0);
      @(negedge clk);
    end
    set_inputs(0, 1'b1);
    @(negedge clk);
    check("mid_nb", nb, 1);
    check("mid_flag", flag, 1);
    set_inputs(0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_nb", nb, 0);
    check("mrst_first", first, 0);
    check("mrst_flag", flag, 0);
    check("mrst_pass", pass, 0);
    run_main("after_rst", 0, '0, 1'b0);

    // Saturating instance: alternating mismatches give 5 episodes, clamped to 3.
    mis_q.delete();
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    check("sat_busy", busy2, 1);
    for (int i = 0; i < RN2; i++) begin
      start2 = (i == 4);
      g2 = W2'($urandom);
      k2 = '1;
      b2 = (i % 2 == 0) ? ~g2 : g2;
      mis_q.push_back(i % 2 == 0);
      @(negedge clk);
    end
    start2 = 1'b0;
    check("sat_done", done2, 1);
    check("sat_nb", nb2, exp_episodes(2 ** EW2 - 1));
    check("sat_first", first2, exp_first());
    check("sat_pass", pass2, 0);
    check("sat_flag", flag2, mis_q[RN2-1]);
    start2 = 1'b1;
    b2 = g2;
    @(negedge clk);
    start2 = 1'b0;
    check("restart_nb", nb2, 0);
    check("restart_busy", busy2, 1);
    check("restart_done", done2, 0);
    check("restart_first", first2, 0);
    for (int i = 0; i < RN2; i++) begin
      g2 = W2'($urandom);
      b2 = g2;
      @(negedge clk);
    end
    check("restart_pass", pass2, 1);
    check("restart_nb_end", nb2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
